// File: rtl/imem_access_arbiter_if.sv
// Bus bundle between the fetch port, the loader port, the IM array and the arbiter.
// slave = arbiter side; master = requesters plus the memory array.
interface imem_access_arbiter_if;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_err;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        l_req;
  logic [31:0] l_addr;
  logic [31:0] l_data;
  logic        wr_en;
  logic        l_gnt;
  logic        l_err;
  logic        im_cs;
  logic        im_wr;
  logic        im_rd;
  logic [31:0] im_addr;
  logic [31:0] im_din;
  logic [31:0] im_dout;

  modport slave (
    input  f_req, f_addr, l_req, l_addr, l_data, wr_en, im_dout,
    output f_gnt, f_err, f_rvalid, f_rdata, l_gnt, l_err,
           im_cs, im_wr, im_rd, im_addr, im_din
  );

  modport master (
    output f_req, f_addr, l_req, l_addr, l_data, wr_en, im_dout,
    input  f_gnt, f_err, f_rvalid, f_rdata, l_gnt, l_err,
           im_cs, im_wr, im_rd, im_addr, im_din
  );
endinterface

// File: rtl/imem_access_arbiter.sv
// Sole master of the instruction memory: arbitrates fetch reads against loader writes,
// issues one-cycle memory commands and rejects misaligned, out-of-range or unpermitted requests.
module imem_access_arbiter #(
  parameter int ADDR_LIMIT = 4096,
  parameter int LOADER_MAX = 4
) (
  input logic                  clk,
  input logic                  reset,
  imem_access_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam int              BW        = $clog2(LOADER_MAX + 1);
  localparam logic [31:0]     LAST_WORD = 32'(ADDR_LIMIT - 4);
  localparam logic [BW-1:0]   BURST_MAX = BW'(LOADER_MAX);

  logic [1:0]    state;
  logic [BW-1:0] burst;
  logic          pick_f;
  logic          pick_l;
  logic          f_bad;
  logic          l_bad;

  // Loader wins contention until it has used up its burst allowance.
  always_comb begin
    pick_f = bus.f_req && (!bus.l_req || burst == BURST_MAX);
    pick_l = bus.l_req && !pick_f;
    f_bad  = (bus.f_addr[1:0] != 2'b00) || (bus.f_addr > LAST_WORD);
    l_bad  = (bus.l_addr[1:0] != 2'b00) || (bus.l_addr > LAST_WORD) || !bus.wr_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      burst        <= '0;
      bus.f_gnt    <= 1'b0;
      bus.f_err    <= 1'b0;
      bus.f_rvalid <= 1'b0;
      bus.f_rdata  <= '0;
      bus.l_gnt    <= 1'b0;
      bus.l_err    <= 1'b0;
      bus.im_cs    <= 1'b0;
      bus.im_wr    <= 1'b0;
      bus.im_rd    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_din   <= '0;
    end else begin
      bus.f_gnt    <= 1'b0;
      bus.f_err    <= 1'b0;
      bus.f_rvalid <= 1'b0;
      bus.l_gnt    <= 1'b0;
      bus.l_err    <= 1'b0;
      bus.im_cs    <= 1'b0;
      bus.im_wr    <= 1'b0;
      bus.im_rd    <= 1'b0;
      state        <= IDLE;

      case (state)
        IDLE: begin
          if (pick_f) begin
            bus.f_gnt <= 1'b1;
            if (f_bad) begin
              bus.f_err <= 1'b1;
              state     <= ERR;
            end else begin
              bus.im_cs   <= 1'b1;
              bus.im_rd   <= 1'b1;
              bus.im_addr <= bus.f_addr;
              state       <= RD;
            end
          end else if (pick_l) begin
            bus.l_gnt <= 1'b1;
            if (l_bad) begin
              bus.l_err <= 1'b1;
              state     <= ERR;
            end else begin
              bus.im_cs   <= 1'b1;
              bus.im_wr   <= 1'b1;
              bus.im_addr <= bus.l_addr;
              bus.im_din  <= bus.l_data;
              state       <= WR;
            end
          end
        end
        RD: begin
          bus.f_rdata  <= bus.im_dout;
          bus.f_rvalid <= 1'b1;
        end
        default: ;
      endcase

      // Rejected loader requests still count toward the burst, so an erroring loader cannot starve fetch.
      if (!bus.f_req || (state == IDLE && pick_f))
        burst <= '0;
      else if (state == IDLE && pick_l && burst != BURST_MAX)
        burst <= burst + BW'(1);
    end
  end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Bench for imem_access_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_imem_access_arbiter;
  localparam int ADDR_LIMIT = 4096;
  localparam int LOADER_MAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  imem_access_arbiter_if bus();

  imem_access_arbiter #(.ADDR_LIMIT(ADDR_LIMIT), .LOADER_MAX(LOADER_MAX)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] imem    [1024];
  logic [31:0] ref_mem [1024];

  assign bus.im_dout = imem[bus.im_addr[11:2]];

  function automatic logic [31:0] init_word(int i);
    return {16'hC0DE, 16'(i)};
  endfunction

  function automatic bit addr_ok(logic [31:0] a);
    return (a % 4 == 0) && (a <= 32'(ADDR_LIMIT - 4));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory array behind the arbiter: commits on the edge that ends a write command.
  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.im_cs && bus.im_wr) imem[bus.im_addr[11:2]] <= bus.im_din;
    end
  end

  // Reference model: an access occupies the arbiter for two cycles (decision, then command);
  // expectations below are for the cycle that follows the next rising edge.
  logic        e_f_gnt = 0, e_f_err = 0, e_f_rvalid = 0, e_l_gnt = 0, e_l_err = 0;
  logic        e_cs = 0, e_wr = 0, e_rd = 0;
  logic [31:0] e_rdata = 0, e_addr = 0, e_din = 0;
  bit          m_busy = 0, m_rd = 0, m_wr = 0;
  int          m_burst = 0;
  logic [31:0] m_addr = 0, m_data = 0;

  initial begin
    bit fetch_wins;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (reset) begin
        {e_f_gnt, e_f_err, e_f_rvalid, e_l_gnt, e_l_err, e_cs, e_wr, e_rd} = '0;
        e_rdata = 0; e_addr = 0; e_din = 0;
        m_busy = 0; m_rd = 0; m_wr = 0; m_burst = 0;
      end
      chk("f_gnt",    32'(bus.f_gnt),    32'(e_f_gnt));
      chk("f_err",    32'(bus.f_err),    32'(e_f_err));
      chk("f_rvalid", 32'(bus.f_rvalid), 32'(e_f_rvalid));
      chk("f_rdata",  bus.f_rdata,       e_rdata);
      chk("l_gnt",    32'(bus.l_gnt),    32'(e_l_gnt));
      chk("l_err",    32'(bus.l_err),    32'(e_l_err));
      chk("im_cs",    32'(bus.im_cs),    32'(e_cs));
      chk("im_wr",    32'(bus.im_wr),    32'(e_wr));
      chk("im_rd",    32'(bus.im_rd),    32'(e_rd));
      chk("im_addr",  bus.im_addr,       e_addr);
      chk("im_din",   bus.im_din,        e_din);
      if (!reset) begin
        {e_f_gnt, e_f_err, e_f_rvalid, e_l_gnt, e_l_err, e_cs, e_wr, e_rd} = '0;
        if (m_busy) begin
          m_busy = 0;
          if (m_rd) begin e_f_rvalid = 1; e_rdata = ref_mem[m_addr[11:2]]; end
          if (m_wr) ref_mem[m_addr[11:2]] = m_data;
          m_rd = 0; m_wr = 0;
        end else begin
          fetch_wins = bus.f_req && (!bus.l_req || m_burst >= LOADER_MAX);
          if (fetch_wins) begin
            m_busy = 1; e_f_gnt = 1;
            if (!addr_ok(bus.f_addr)) e_f_err = 1;
            else begin e_cs = 1; e_rd = 1; e_addr = bus.f_addr; m_rd = 1; m_addr = bus.f_addr; end
            m_burst = 0;
          end else if (bus.l_req) begin
            m_busy = 1; e_l_gnt = 1;
            if (!addr_ok(bus.l_addr) || !bus.wr_en) e_l_err = 1;
            else begin
              e_cs = 1; e_wr = 1; e_addr = bus.l_addr; e_din = bus.l_data;
              m_wr = 1; m_addr = bus.l_addr; m_data = bus.l_data;
            end
            if (bus.f_req) m_burst = (m_burst + 1 > LOADER_MAX) ? LOADER_MAX : m_burst + 1;
          end
        end
        if (!bus.f_req) m_burst = 0;
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a, output bit err, output bit rv,
                          output logic [31:0] data, output int lat);
    bit got;
    @(posedge clk); #2;
    bus.f_req = 1; bus.f_addr = a; lat = 0; got = 0; err = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #2; lat++;
      if (bus.f_gnt) begin got = 1; err = bus.f_err; bus.f_req = 0; end
    end
    chk("fetch_gnt_seen", 32'(got), 32'd1);
    bus.f_req = 0;
    @(posedge clk); #2; lat++;
    rv = bus.f_rvalid; data = bus.f_rdata;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, output bit err);
    bit got;
    @(posedge clk); #2;
    bus.l_req = 1; bus.l_addr = a; bus.l_data = d; got = 0; err = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #2;
      if (bus.l_gnt) begin got = 1; err = bus.l_err; bus.l_req = 0; end
    end
    chk("write_gnt_seen", 32'(got), 32'd1);
    bus.l_req = 0;
    @(posedge clk); #2;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0: a = 32'hFFC;
      1: a = 32'h1000;
      2: begin a = $urandom_range(0, 15); a = (a << 2) | 32'($urandom_range(1, 3)); end
      3: a = $urandom;
      default: begin a = $urandom_range(0, 15); a = a << 2; end
    endcase
    return a;
  endfunction

  initial begin
    bit err, rv, got, gap_bad;
    logic [31:0] data;
    logic [4:0] order;
    int lat, n, last;

    bus.f_req = 0; bus.f_addr = 0; bus.l_req = 0; bus.l_addr = 0; bus.l_data = 0; bus.wr_en = 1;
    #1 reset = 1;
    repeat (2) @(posedge clk);
    #2 reset = 0;

    // Loader write, then fetch the same word back.
    do_write(32'h10, 32'hDEADBEEF, err);
    chk("t1_write_err", 32'(err), 32'd0);
    do_fetch(32'h10, err, rv, data, lat);
    chk("t1_fetch_err", 32'(err), 32'd0);
    chk("t1_rvalid", 32'(rv), 32'd1);
    chk("t1_latency", 32'(lat), 32'd2);
    chk("t1_rdata", data, 32'hDEADBEEF);

    // Misaligned and out-of-range fetches are rejected and leave f_rdata alone.
    do_fetch(32'h2, err, rv, data, lat);
    chk("t3_mis_err", 32'(err), 32'd1);
    chk("t3_mis_rvalid", 32'(rv), 32'd0);
    chk("t3_mis_rdata", data, 32'hDEADBEEF);
    do_fetch(32'h1000, err, rv, data, lat);
    chk("t3_oor_err", 32'(err), 32'd1);
    chk("t3_oor_rdata", data, 32'hDEADBEEF);

    // Write without permit is rejected; memory keeps its old contents.
    bus.wr_en = 0;
    do_write(32'h20, 32'h12345678, err);
    chk("t4_write_err", 32'(err), 32'd1);
    bus.wr_en = 1;
    do_fetch(32'h20, err, rv, data, lat);
    chk("t4_rdata", data, 32'hC0DE0008);

    // Boundary words.
    do_write(32'hFFC, 32'h0BADF00D, err);
    chk("t5_hi_err", 32'(err), 32'd0);
    do_write(32'h0, 32'h600DCAFE, err);
    chk("t5_lo_err", 32'(err), 32'd0);
    do_fetch(32'hFFC, err, rv, data, lat);
    chk("t5_hi_rdata", data, 32'h0BADF00D);
    do_fetch(32'h0, err, rv, data, lat);
    chk("t5_lo_rdata", data, 32'h600DCAFE);

    // Contended requests: four loader grants then the fetch.
    @(posedge clk); #2;
    bus.f_req = 1; bus.f_addr = 32'h40; bus.l_req = 1; bus.l_addr = 32'h80; bus.l_data = 32'h5A5A5A5A;
    n = 0; last = 0; gap_bad = 0; order = '0;
    for (int c = 1; c <= 40 && n < 5; c++) begin
      @(posedge clk); #2;
      if (bus.l_gnt || bus.f_gnt) begin
        order[4-n] = bus.l_gnt;
        if (n > 0 && c - last != 2) gap_bad = 1;
        last = c; n++;
      end
    end
    bus.f_req = 0; bus.l_req = 0;
    chk("t2_grant_count", 32'(n), 32'd5);
    chk("t2_grant_order", 32'(order), 32'h1E);
    chk("t2_grant_gap", 32'(gap_bad), 32'd0);
    repeat (3) @(posedge clk);

    // Reset during the write command: strobe drops at once, word unchanged.
    @(posedge clk); #2;
    bus.l_req = 1; bus.l_addr = 32'h30; bus.l_data = 32'hFFFF0000;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #2;
      if (bus.l_gnt) got = 1;
    end
    chk("t6_wr_gnt_seen", 32'(got), 32'd1);
    reset = 1; bus.l_req = 0;
    #1;
    chk("t6_im_cs", 32'(bus.im_cs), 32'd0);
    chk("t6_im_wr", 32'(bus.im_wr), 32'd0);
    chk("t6_l_gnt", 32'(bus.l_gnt), 32'd0);
    chk("t6_f_rdata", bus.f_rdata, 32'd0);
    @(posedge clk); #2;
    reset = 0;
    do_fetch(32'h30, err, rv, data, lat);
    chk("t6_rdata", data, 32'hC0DE000C);

    // Random traffic.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #2;
      if (bus.f_gnt) bus.f_req = 0;
      else if (!bus.f_req && $urandom_range(0, 2) == 0) begin bus.f_req = 1; bus.f_addr = rand_addr(); end
      if (bus.l_gnt) bus.l_req = 0;
      else if (!bus.l_req && $urandom_range(0, 2) == 0) begin
        bus.l_req = 1; bus.l_addr = rand_addr(); bus.l_data = $urandom;
      end
      if ($urandom_range(0, 9) == 0) bus.wr_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1; bus.f_req = 0; bus.l_req = 0;
        @(posedge clk); #2;
        reset = 0;
      end
    end
    bus.f_req = 0; bus.l_req = 0;
    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
